// File: rtl/gg_slice_pkg.sv
// Shared definitions for the row-slice writer and the row-slice lattice parser.
//   - syntax element enum, writer FSM state, VLC payload struct
//   - Exp-Golomb limits and widths
package gg_slice_pkg;

  localparam int unsigned CODE_W        = 32;  // out_code width
  localparam int unsigned LEN_W         = 6;   // out_len width
  localparam int unsigned NBITS_W       = 3;   // mb_nbits / bit_pos width
  localparam int unsigned EG_IN_W       = 16;  // Exp-Golomb encoder input width
  localparam int unsigned EG_MAX_PREFIX = 15;  // longest ue/se prefix (31-bit code)

  // slice_layer_rbsp() syntax elements, in bitstream order
  typedef enum logic [3:0] {
    EL_FIRST_MB,
    EL_SLICE_TYPE,
    EL_PPS_ID,
    EL_FRAME_NUM,
    EL_POC_LSB,
    EL_FLAGS,
    EL_QP_DELTA,
    EL_DBLK_IDC,
    EL_ALPHA_DIV2,
    EL_BETA_DIV2,
    EL_SKIP_RUN
  } syn_elem_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_MB,
    ST_RUN,
    ST_MB_BUSY,
    ST_TRAIL
  } wr_state_e;

  // right-aligned variable-length code
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } vlc_t;

endpackage

// File: rtl/gg_slice_rowslice_writer_if.sv
// MB-descriptor / MB-encoder sequencing and code-output channels of the writer.
//   master: writer side (drives mb_ready, mb_start, out_valid/code/len)
//   slave : environment side (MB source, MB encoder, bit packer)
interface gg_slice_rowslice_writer_if;
  import gg_slice_pkg::*;

  logic               mb_valid;
  logic               mb_skip;
  logic               mb_last;
  logic               mb_ready;
  logic               mb_start;
  logic               mb_end;
  logic [NBITS_W-1:0] mb_nbits;
  logic               out_valid;
  logic               out_ready;
  logic [CODE_W-1:0]  out_code;
  logic [LEN_W-1:0]   out_len;

  modport master (
    input  mb_valid, mb_skip, mb_last, mb_end, mb_nbits, out_ready,
    output mb_ready, mb_start, out_valid, out_code, out_len
  );

  modport slave (
    output mb_valid, mb_skip, mb_last, mb_end, mb_nbits, out_ready,
    input  mb_ready, mb_start, out_valid, out_code, out_len
  );

endinterface

// File: rtl/gg_expgolomb_enc.sv
// Combinational Exp-Golomb encoder: value -> {code, len} for ue(v) or se(v).
//   val   : unsigned value (ue) or two's-complement value (se)
//   is_se : select signed mapping k>0 -> 2k-1, k<=0 -> -2k
//   vlc   : code = mapped+1 right aligned, len = 2*prefix+1
module gg_expgolomb_enc
  import gg_slice_pkg::*;
(
  input  logic [EG_IN_W-1:0] val,
  input  logic               is_se,
  output vlc_t               vlc
);

  logic [EG_IN_W:0]   mapped;
  logic [EG_IN_W+1:0] val_p1;
  logic [4:0]         prefix;

  // signed mapping, then prefix = floor(log2(v+1))
  always_comb begin
    if (!is_se) begin
      mapped = {1'b0, val};
    end else if (!val[EG_IN_W-1] && (val != '0)) begin
      mapped = {val, 1'b0} - (EG_IN_W+1)'(1);
    end else begin
      mapped = (EG_IN_W+1)'(0) - {val, 1'b0};
    end
    val_p1 = {1'b0, mapped} + (EG_IN_W+2)'(1);
    prefix = '0;
    for (int i = 0; i < EG_IN_W + 2; i++) begin
      if (val_p1[i]) prefix = 5'(i);
    end
    // out-of-range values saturate to the longest legal code length
    if (prefix > 5'(EG_MAX_PREFIX)) prefix = 5'(EG_MAX_PREFIX);
    vlc.code = CODE_W'(val_p1);
    vlc.len  = LEN_W'({prefix, 1'b1});
  end

endmodule

// File: rtl/gg_slice_rowslice_writer.sv
// Row-slice slice_layer_rbsp() writer: emits the slice header, skip runs and
// rbsp trailing bits as VLCs, and sequences the MB encoder in between.
//   clk, reset (async, active low)
//   slice_start + header fields : captured in IDLE only
//   bus (master)                : MB descriptors, mb_start/mb_end, code output
//   slice_busy / slice_end      : slice in progress / done pulse
module gg_slice_rowslice_writer
  import gg_slice_pkg::*;
#(
  parameter int unsigned FIRST_MB_W = 16,
  parameter int unsigned RUN_W      = 8,
  parameter int unsigned SLICE_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slice_start,
  input  logic [FIRST_MB_W-1:0] first_mb,
  input  logic [7:0]            pps_id,
  input  logic [3:0]            frame_num,
  input  logic [3:0]            poc_lsb,
  input  logic [6:0]            qp_delta,
  input  logic [1:0]            dblk_idc,
  input  logic [3:0]            alpha_div2,
  input  logic [3:0]            beta_div2,
  gg_slice_rowslice_writer_if.master bus,
  output logic                  slice_busy,
  output logic                  slice_end
);

  wr_state_e           state_q, state_d;
  syn_elem_e           elem_q, elem_d, elem_nxt, enc_elem;
  logic                out_valid_q, out_valid_d;
  logic [CODE_W-1:0]   out_code_q, out_code_d;
  logic [LEN_W-1:0]    out_len_q, out_len_d;
  logic                mb_ready_q, mb_ready_d;
  logic                mb_start_q, mb_start_d;
  logic                busy_q, busy_d;
  logic                end_q, end_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [NBITS_W-1:0]  bit_pos_q, bit_pos_d;
  logic                last_q, last_d;
  logic                coded_q, coded_d;

  logic [FIRST_MB_W-1:0] fm_q;
  logic [7:0]            pps_q;
  logic [3:0]            fn_q, poc_q, alpha_q, beta_q;
  logic [6:0]            qp_q;
  logic [1:0]            idc_q;

  logic               cap, fire, last_hdr, enc_se;
  logic [EG_IN_W-1:0] enc_val;
  vlc_t               enc_vlc, hdr_vlc;

  assign cap      = (state_q == ST_IDLE) && slice_start;
  assign fire     = out_valid_q && bus.out_ready;
  assign elem_nxt = syn_elem_e'(elem_q + 4'd1);
  assign last_hdr = (elem_q == EL_BETA_DIV2) ||
                    ((elem_q == EL_DBLK_IDC) && (idc_q == 2'd1));
  // after a transfer the following element is loaded in the same cycle
  assign enc_elem = out_valid_q ? elem_nxt : elem_q;

  // header field capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fm_q    <= '0;
      pps_q   <= '0;
      fn_q    <= '0;
      poc_q   <= '0;
      qp_q    <= '0;
      idc_q   <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
    end else if (cap) begin
      fm_q    <= first_mb;
      pps_q   <= pps_id;
      fn_q    <= frame_num;
      poc_q   <= poc_lsb;
      qp_q    <= qp_delta;
      idc_q   <= dblk_idc;
      alpha_q <= alpha_div2;
      beta_q  <= beta_div2;
    end
  end

  // encoder operand select: skip run in RUN, else the header element
  always_comb begin
    enc_val = '0;
    enc_se  = 1'b0;
    if (state_q == ST_RUN) begin
      enc_val = EG_IN_W'(run_q);
    end else begin
      case (enc_elem)
        EL_FIRST_MB:   enc_val = EG_IN_W'(fm_q);
        EL_SLICE_TYPE: enc_val = EG_IN_W'(SLICE_TYPE);
        EL_PPS_ID:     enc_val = EG_IN_W'(pps_q);
        EL_QP_DELTA:   begin enc_val = {{(EG_IN_W-7){qp_q[6]}}, qp_q};       enc_se = 1'b1; end
        EL_DBLK_IDC:   enc_val = EG_IN_W'(idc_q);
        EL_ALPHA_DIV2: begin enc_val = {{(EG_IN_W-4){alpha_q[3]}}, alpha_q}; enc_se = 1'b1; end
        EL_BETA_DIV2:  begin enc_val = {{(EG_IN_W-4){beta_q[3]}}, beta_q};   enc_se = 1'b1; end
        default:       enc_val = '0;
      endcase
    end
  end

  gg_expgolomb_enc u_eg (
    .val   (enc_val),
    .is_se (enc_se),
    .vlc   (enc_vlc)
  );

  // fixed-length header fields bypass the Exp-Golomb encoder
  always_comb begin
    hdr_vlc = enc_vlc;
    case (enc_elem)
      EL_FRAME_NUM: hdr_vlc = '{code: CODE_W'(fn_q),  len: LEN_W'(4)};
      EL_POC_LSB:   hdr_vlc = '{code: CODE_W'(poc_q), len: LEN_W'(4)};
      EL_FLAGS:     hdr_vlc = '{code: '0,             len: LEN_W'(3)};
      default:      ;
    endcase
  end

  // next state and registered-output values
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;
    mb_start_d  = 1'b0;
    busy_d      = busy_q;
    end_d       = 1'b0;
    run_d       = run_q;
    bit_pos_d   = bit_pos_q;
    last_d      = last_q;
    coded_d     = coded_q;

    if (fire) bit_pos_d = bit_pos_q + out_len_q[NBITS_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (slice_start) begin
          state_d   = ST_HDR;
          elem_d    = EL_FIRST_MB;
          busy_d    = 1'b1;
          run_d     = '0;
          bit_pos_d = '0;
        end
      end
      ST_HDR: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_code_d  = hdr_vlc.code;
          out_len_d   = hdr_vlc.len;
        end else if (bus.out_ready) begin
          if (last_hdr) begin
            out_valid_d = 1'b0;
            state_d     = ST_WAIT_MB;
          end else begin
            elem_d      = elem_nxt;
            out_code_d  = hdr_vlc.code;
            out_len_d   = hdr_vlc.len;
          end
        end
      end
      ST_WAIT_MB: begin
        if (bus.mb_valid && mb_ready_q) begin
          if (bus.mb_skip) begin
            run_d = run_q + RUN_W'(1);
            if (bus.mb_last) begin
              state_d = ST_RUN;
              coded_d = 1'b0;
              last_d  = 1'b1;
            end
          end else begin
            state_d = ST_RUN;
            coded_d = 1'b1;
            last_d  = bus.mb_last;
          end
        end
      end
      ST_RUN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_code_d  = enc_vlc.code;
          out_len_d   = enc_vlc.len;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          run_d       = '0;
          if (coded_q) begin
            mb_start_d = 1'b1;
            state_d    = ST_MB_BUSY;
          end else begin
            state_d    = ST_TRAIL;
          end
        end
      end
      ST_MB_BUSY: begin
        if (bus.mb_end) begin
          bit_pos_d = bit_pos_q + bus.mb_nbits;
          state_d   = last_q ? ST_TRAIL : ST_WAIT_MB;
        end
      end
      ST_TRAIL: begin
        // stop bit plus zero alignment bits up to the byte boundary
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_code_d  = CODE_W'(8'h80 >> bit_pos_q);
          out_len_d   = LEN_W'(4'd8 - {1'b0, bit_pos_q});
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          end_d       = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mb_ready_d = (state_d == ST_WAIT_MB);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      elem_q      <= EL_FIRST_MB;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_len_q   <= '0;
      mb_ready_q  <= 1'b0;
      mb_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      end_q       <= 1'b0;
      run_q       <= '0;
      bit_pos_q   <= '0;
      last_q      <= 1'b0;
      coded_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
      mb_ready_q  <= mb_ready_d;
      mb_start_q  <= mb_start_d;
      busy_q      <= busy_d;
      end_q       <= end_d;
      run_q       <= run_d;
      bit_pos_q   <= bit_pos_d;
      last_q      <= last_d;
      coded_q     <= coded_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_len   = out_len_q;
  assign bus.mb_ready  = mb_ready_q;
  assign bus.mb_start  = mb_start_q;
  assign slice_busy    = busy_q;
  assign slice_end     = end_q;

endmodule

// File: tb/tb_gg_slice_rowslice_writer.sv
// Directed bench for gg_slice_rowslice_writer: captures every transferred code
// and compares against hand-computed slice bitstreams.
module tb_gg_slice_rowslice_writer;
  import gg_slice_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slice_start = 1'b0;
  logic [15:0] first_mb = '0;
  logic [7:0]  pps_id = '0;
  logic [3:0]  frame_num = '0;
  logic [3:0]  poc_lsb = '0;
  logic [6:0]  qp_delta = '0;
  logic [1:0]  dblk_idc = '0;
  logic [3:0]  alpha_div2 = '0;
  logic [3:0]  beta_div2 = '0;
  logic        slice_busy;
  logic        slice_end;

  int          n_checks = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_fire_cyc = 0;

  logic [31:0] got_code[$];
  logic [5:0]  got_len[$];
  logic [31:0] exp_code[$];
  logic [5:0]  exp_len[$];

  gg_slice_rowslice_writer_if bus ();

  gg_slice_rowslice_writer #(
    .FIRST_MB_W (16),
    .RUN_W      (8),
    .SLICE_TYPE (0)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .slice_start (slice_start),
    .first_mb    (first_mb),
    .pps_id      (pps_id),
    .frame_num   (frame_num),
    .poc_lsb     (poc_lsb),
    .qp_delta    (qp_delta),
    .dblk_idc    (dblk_idc),
    .alpha_div2  (alpha_div2),
    .beta_div2   (beta_div2),
    .bus         (bus),
    .slice_busy  (slice_busy),
    .slice_end   (slice_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // packer model: record each transfer, sampled half a cycle before the edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_code.push_back(bus.out_code);
      got_len.push_back(bus.out_len);
      last_fire_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] code, input logic [5:0] len);
    exp_code.push_back(code);
    exp_len.push_back(len);
  endtask

  // header of first_mb=0, pps=0, fn=0, poc=0, qp=0, idc=1 (18 bits)
  task automatic add_hdr_zero();
    add(32'd1, 6'd1); add(32'd1, 6'd1); add(32'd1, 6'd1);
    add(32'd0, 6'd4); add(32'd0, 6'd4); add(32'd0, 6'd3);
    add(32'd1, 6'd1); add(32'd2, 6'd3);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_code"},  64'(bus.out_code),  64'd0);
    check({tag, "_out_len"},   64'(bus.out_len),   64'd0);
    check({tag, "_mb_ready"},  64'(bus.mb_ready),  64'd0);
    check({tag, "_mb_start"},  64'(bus.mb_start),  64'd0);
    check({tag, "_busy"},      64'(slice_busy),    64'd0);
    check({tag, "_end"},       64'(slice_end),     64'd0);
  endtask

  task automatic start_slice(input logic [15:0] fm, input logic [7:0] pps, input logic [3:0] fn,
                             input logic [3:0] poc, input logic [6:0] qp, input logic [1:0] idc,
                             input logic [3:0] a, input logic [3:0] b);
    first_mb = fm; pps_id = pps; frame_num = fn; poc_lsb = poc;
    qp_delta = qp; dblk_idc = idc; alpha_div2 = a; beta_div2 = b;
    slice_start = 1'b1;
    tick();
    slice_start = 1'b0;
  endtask

  task automatic send_mb(input string tag, input logic skip, input logic last);
    bit ok = 1'b0;
    bus.mb_valid = 1'b1; bus.mb_skip = skip; bus.mb_last = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.mb_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_mb_accept"}, 64'd0, 64'd1);
    tick();
    bus.mb_valid = 1'b0; bus.mb_skip = 1'b0; bus.mb_last = 1'b0;
  endtask

  // MB encoder model: wait for mb_start, optionally answer with mb_end
  task automatic serve_mb(input string tag, input logic [2:0] nb, input bit respond);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.mb_start) begin ok = 1'b1; break; end
    end
    check({tag, "_mb_start_seen"}, 64'(ok), 64'd1);
    if (ok) check({tag, "_mb_start_gap"}, 64'(cyc - last_fire_cyc), 64'd1);
    tick();
    if (ok && respond) begin
      tick();
      bus.mb_end = 1'b1; bus.mb_nbits = nb;
      tick();
      bus.mb_end = 1'b0; bus.mb_nbits = '0;
    end
  endtask

  task automatic wait_end(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (slice_end) begin ok = 1'b1; break; end
    end
    check({tag, "_end_seen"}, 64'(ok), 64'd1);
    check({tag, "_busy_at_end"}, 64'(slice_busy), 64'd0);
    @(negedge clk);
    check({tag, "_end_pulse"}, 64'(slice_end), 64'd0);
    tick();
  endtask

  task automatic compare(input string tag, input int base);
    int n = got_code.size() - base;
    check({tag, "_ncodes"}, 64'(n), 64'(exp_code.size()));
    for (int i = 0; i < exp_code.size(); i++) begin
      if (base + i < got_code.size()) begin
        check($sformatf("%s_code%0d", tag, i), 64'(got_code[base+i]), 64'(exp_code[i]));
        check($sformatf("%s_len%0d", tag, i),  64'(got_len[base+i]),  64'(exp_len[i]));
      end
    end
    exp_code.delete();
    exp_len.delete();
  endtask

  // one coded last MB with nbits=5 on the all-zero header, idc=1
  task automatic run_basic(input string tag);
    int base = got_code.size();
    start_slice(16'd0, 8'd0, 4'd0, 4'd0, 7'd0, 2'd1, 4'd0, 4'd0);
    check({tag, "_busy"}, 64'(slice_busy), 64'd1);
    send_mb(tag, 1'b0, 1'b1);
    serve_mb(tag, 3'd5, 1'b1);
    wait_end(tag);
    add_hdr_zero();
    add(32'd1, 6'd1);
    add(32'h80, 6'd8);
    compare(tag, base);
  endtask

  initial begin
    int base;
    logic [31:0] snap_code;
    logic [5:0]  snap_len;
    bit ok;

    bus.mb_valid = 1'b0; bus.mb_skip = 1'b0; bus.mb_last = 1'b0;
    bus.mb_end = 1'b0; bus.mb_nbits = '0; bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check_outs_zero("idle");

    // 1: minimal header, one coded last MB
    run_basic("t1");

    // 2: deblocking offsets present, signed fields; bit_pos 3 before trailing
    base = got_code.size();
    start_slice(16'd5, 8'd3, 4'd9, 4'd10, 7'b1111101, 2'd0, 4'hF, 4'd2);
    send_mb("t2", 1'b0, 1'b1);
    serve_mb("t2", 3'd6, 1'b1);
    wait_end("t2");
    add(32'd6, 6'd5); add(32'd1, 6'd1); add(32'd4, 6'd5); add(32'd9, 6'd4);
    add(32'd10, 6'd4); add(32'd0, 6'd3); add(32'd7, 6'd5); add(32'd1, 6'd1);
    add(32'd3, 6'd3); add(32'd4, 6'd5);
    add(32'd1, 6'd1);
    add(32'h10, 6'd5);
    compare("t2", base);

    // 3: three skipped MBs then a coded last MB -> ue(3); bit_pos 7
    base = got_code.size();
    start_slice(16'd0, 8'd0, 4'd0, 4'd0, 7'd0, 2'd1, 4'd0, 4'd0);
    send_mb("t3", 1'b1, 1'b0);
    send_mb("t3", 1'b1, 1'b0);
    send_mb("t3", 1'b1, 1'b0);
    send_mb("t3", 1'b0, 1'b1);
    serve_mb("t3", 3'd0, 1'b1);
    wait_end("t3");
    add_hdr_zero();
    add(32'd4, 6'd5);
    add(32'd1, 6'd1);
    compare("t3", base);

    // 4: coded MB, then two skips with the last flagged; stray
    //    slice_start and mb_end during the header must be ignored
    base = got_code.size();
    start_slice(16'd0, 8'd0, 4'd0, 4'd0, 7'd0, 2'd1, 4'd0, 4'd0);
    tick();
    slice_start = 1'b1; first_mb = 16'd7; bus.mb_end = 1'b1; bus.mb_nbits = 3'd7;
    tick();
    slice_start = 1'b0; first_mb = 16'd0; bus.mb_end = 1'b0; bus.mb_nbits = '0;
    send_mb("t4", 1'b0, 1'b0);
    serve_mb("t4", 3'd4, 1'b1);
    send_mb("t4", 1'b1, 1'b0);
    send_mb("t4", 1'b1, 1'b1);
    wait_end("t4");
    add_hdr_zero();
    add(32'd1, 6'd1);
    add(32'd3, 6'd3);
    add(32'h20, 6'd6);
    compare("t4", base);

    // 5: packer stall of 5 cycles in the middle of the header
    base = got_code.size();
    start_slice(16'd0, 8'd0, 4'd0, 4'd0, 7'd0, 2'd1, 4'd0, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (got_code.size() - base >= 3) begin ok = 1'b1; break; end
    end
    check("t5_hdr_progress", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    snap_code = bus.out_code;
    snap_len  = bus.out_len;
    check("t5_valid_in_stall", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t5_stable_code%0d", i), 64'(bus.out_code), 64'(snap_code));
      check($sformatf("t5_stable_len%0d", i),  64'(bus.out_len),  64'(snap_len));
      check($sformatf("t5_stable_vld%0d", i),  64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_mb("t5", 1'b0, 1'b1);
    serve_mb("t5", 3'd5, 1'b1);
    wait_end("t5");
    add_hdr_zero();
    add(32'd1, 6'd1);
    add(32'h80, 6'd8);
    compare("t5", base);

    // 6: reset while the MB encoder is busy, then a fresh slice
    start_slice(16'd0, 8'd0, 4'd0, 4'd0, 7'd0, 2'd1, 4'd0, 4'd0);
    send_mb("t6", 1'b0, 1'b1);
    serve_mb("t6", 3'd0, 1'b0);
    check("t6_busy_before_reset", 64'(slice_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs_zero("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("t6_idle_ready", 64'(bus.mb_ready), 64'd0);
    run_basic("t6_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
